// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default
// geometry, derived tag width and the controller state encoding.
package instruction_cache_pkg;

    // Default geometry: 4 words per line, 64 lines.
    localparam int BLOCK_WIDTH_DEFAULT = 2;
    localparam int CACHE_WIDTH_DEFAULT = 6;

    // Everything above the index and offset fields (and the byte offset) is tag.
    function automatic int tagWidth(input int blockWidth, input int cacheWidth);
        return 32 - cacheWidth - blockWidth - 2;
    endfunction

    localparam int TAG_WIDTH_DEFAULT = tagWidth(BLOCK_WIDTH_DEFAULT, CACHE_WIDTH_DEFAULT);

    // Controller states: serving lookups, or filling a line from memory.
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } cacheState_t;

endpackage

// File: rtl/icache_line_store.sv
// Storage for the instruction cache: per-line data words, tags and valid
// bits. Reads are combinational; a single write port is driven by the fill
// logic. Only the valid bits are cleared by reset.
module icache_line_store
    import instruction_cache_pkg::*;
#(
    parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEFAULT,
    parameter int CACHE_WIDTH = CACHE_WIDTH_DEFAULT,
    parameter int TAG_WIDTH   = tagWidth(BLOCK_WIDTH, CACHE_WIDTH)
) (
    input  logic                   clockIn,
    input  logic                   resetIn,
    input  logic [CACHE_WIDTH-1:0] readIndex,
    input  logic [BLOCK_WIDTH-1:0] readOffset,
    output logic [31:0]            readData,
    output logic [TAG_WIDTH-1:0]   readTag,
    output logic                   readValid,
    input  logic                   writeEnable,
    input  logic [CACHE_WIDTH-1:0] writeIndex,
    input  logic [BLOCK_WIDTH-1:0] writeOffset,
    input  logic [31:0]            writeData,
    input  logic                   validSet,
    input  logic                   validClear,
    input  logic [CACHE_WIDTH-1:0] validIndex,
    input  logic [TAG_WIDTH-1:0]   tagData
);

    localparam int LINES = 1 << CACHE_WIDTH;
    localparam int WORDS = 1 << BLOCK_WIDTH;

    logic [31:0]          dataArray [0:LINES-1][0:WORDS-1];
    logic [TAG_WIDTH-1:0] tagArray  [0:LINES-1];
    logic [LINES-1:0]     validBits;

    assign readData  = dataArray[readIndex][readOffset];
    assign readTag   = tagArray[readIndex];
    assign readValid = validBits[readIndex];

    // Fill beats land in the data array one word at a time; no reset needed.
    always_ff @(posedge clockIn) begin
        if (writeEnable) begin
            dataArray[writeIndex][writeOffset] <= writeData;
        end
    end

    // The tag is recorded when the line is marked valid at the end of a fill.
    always_ff @(posedge clockIn) begin
        if (validSet) begin
            tagArray[validIndex] <= tagData;
        end
    end

    // Valid bits: cleared on reset and on fill entry, set on the final beat.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            validBits <= '0;
        end else if (validSet) begin
            validBits[validIndex] <= 1'b1;
        end else if (validClear) begin
            validBits[validIndex] <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache. Hits return the word one
// cycle after the request; misses fetch a whole line from memory one word
// per beat and then serve the request with a fresh lookup.
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEFAULT,
    parameter int CACHE_WIDTH = CACHE_WIDTH_DEFAULT
) (
    input  logic        clockIn,
    input  logic        resetIn,
    input  logic        addrValid,
    input  logic [31:0] addrIn,
    output logic        instrOutValid,
    output logic [31:0] instrOut,
    output logic [31:0] instrAddrOut,
    output logic        memRequest,
    output logic [31:0] memAddr,
    input  logic        memDataValid,
    input  logic [31:0] memDataIn
);

    localparam int TAG_WIDTH = tagWidth(BLOCK_WIDTH, CACHE_WIDTH);
    localparam int INDEX_LO  = BLOCK_WIDTH + 2;
    localparam int TAG_LO    = CACHE_WIDTH + BLOCK_WIDTH + 2;

    cacheState_t            state, stateNext;
    logic [BLOCK_WIDTH-1:0] counter, counterNext;

    logic        instrOutValidNext;
    logic [31:0] instrOutNext;
    logic [31:0] instrAddrOutNext;
    logic        memRequestNext;
    logic [31:0] memAddrNext;

    logic [CACHE_WIDTH-1:0] lookupIndex;
    logic [BLOCK_WIDTH-1:0] lookupOffset;
    logic [TAG_WIDTH-1:0]   lookupTag;
    logic [31:0]            wordAddr;
    logic [31:0]            lineAddr;
    logic [CACHE_WIDTH-1:0] fillIndex;
    logic [TAG_WIDTH-1:0]   fillTag;

    logic [31:0]            readData;
    logic [TAG_WIDTH-1:0]   readTag;
    logic                   readValid;
    logic                   lookupHit;

    logic                   storeWrite;
    logic                   validSet;
    logic                   validClear;
    logic [CACHE_WIDTH-1:0] validIndex;

    assign lookupOffset = addrIn[INDEX_LO-1:2];
    assign lookupIndex  = addrIn[TAG_LO-1:INDEX_LO];
    assign lookupTag    = addrIn[31:TAG_LO];
    assign wordAddr     = addrIn & ~32'h3;
    assign lineAddr     = {addrIn[31:INDEX_LO], {INDEX_LO{1'b0}}};

    // The latched fill address doubles as the record of which line is filling.
    assign fillIndex = memAddr[TAG_LO-1:INDEX_LO];
    assign fillTag   = memAddr[31:TAG_LO];

    assign lookupHit = readValid && (readTag == lookupTag);

    icache_line_store #(
        .BLOCK_WIDTH (BLOCK_WIDTH),
        .CACHE_WIDTH (CACHE_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
    ) lineStore (
        .clockIn     (clockIn),
        .resetIn     (resetIn),
        .readIndex   (lookupIndex),
        .readOffset  (lookupOffset),
        .readData    (readData),
        .readTag     (readTag),
        .readValid   (readValid),
        .writeEnable (storeWrite),
        .writeIndex  (fillIndex),
        .writeOffset (counter),
        .writeData   (memDataIn),
        .validSet    (validSet),
        .validClear  (validClear),
        .validIndex  (validIndex),
        .tagData     (fillTag)
    );

    // Next-state, next-output and storage-write decisions for both states.
    always_comb begin
        stateNext         = state;
        counterNext       = counter;
        instrOutValidNext = 1'b0;
        instrOutNext      = instrOut;
        instrAddrOutNext  = instrAddrOut;
        memRequestNext    = memRequest;
        memAddrNext       = memAddr;
        storeWrite        = 1'b0;
        validSet          = 1'b0;
        validClear        = 1'b0;
        validIndex        = lookupIndex;

        case (state)
            IDLE: begin
                if (addrValid) begin
                    if (lookupHit) begin
                        instrOutValidNext = 1'b1;
                        instrOutNext      = readData;
                        instrAddrOutNext  = wordAddr;
                    end else begin
                        memAddrNext    = lineAddr;
                        memRequestNext = 1'b1;
                        counterNext    = '0;
                        validClear     = 1'b1;
                        validIndex     = lookupIndex;
                        stateNext      = FILL;
                    end
                end
            end
            FILL: begin
                if (memDataValid) begin
                    storeWrite  = 1'b1;
                    counterNext = counter + 1'b1;
                    if (counter == '1) begin
                        validSet       = 1'b1;
                        validIndex     = fillIndex;
                        memRequestNext = 1'b0;
                        stateNext      = IDLE;
                    end
                end
            end
        endcase
    end

    // Controller state and beat counter.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            state   <= stateNext;
            counter <= counterNext;
        end
    end

    // Registered outputs; reset drops the fill request without waiting for a clock.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            instrOutValid <= 1'b0;
            instrOut      <= '0;
            instrAddrOut  <= '0;
            memRequest    <= 1'b0;
            memAddr       <= '0;
        end else begin
            instrOutValid <= instrOutValidNext;
            instrOut      <= instrOutNext;
            instrAddrOut  <= instrAddrOutNext;
            memRequest    <= memRequestNext;
            memAddr       <= memAddrNext;
        end
    end

endmodule
